// File: rtl/ped_pkg.sv
// ----------------------------------------------------------------------------
// ped_pkg
// Shared definitions for the pedestrian signal controller: the FSM state
// encoding and the default values of the timing parameters.
// ----------------------------------------------------------------------------
package ped_pkg;

    typedef enum logic [1:0] {
        DW_STEADY = 2'd0,
        WALK      = 2'd1,
        CLEARANCE = 2'd2
    } ped_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_WALK_CYCLES     = 30;
    localparam int DEF_CLEAR_CYCLES    = 15;
    localparam int DEF_FLASH_HALF      = 2;
    localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/ped_btn_debounce.sv
// ----------------------------------------------------------------------------
// ped_btn_debounce
// Brings the raw push-button into the clock domain with a 2-FF synchronizer
// and qualifies it with a saturating run-length counter. A single-cycle press
// pulse is produced when the synchronized level has been high for
// DEBOUNCE_CYCLES consecutive cycles; the level must return low before the
// next pulse can occur.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_btn    in   raw asynchronous button, active high
//   o_press  out  one-cycle qualified press pulse
// ----------------------------------------------------------------------------
module ped_btn_debounce
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt != DB_W'(DEBOUNCE_CYCLES)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Fires in the cycle whose edge brings the count to DEBOUNCE_CYCLES, so the
    // downstream request latch is set on that same edge. Saturation keeps it
    // from firing again until the level drops.
    assign o_press = r_sync2 && (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/ped_signal_ctrl.sv
// ----------------------------------------------------------------------------
// ped_signal_ctrl
// Pedestrian WALK / DON'T-WALK controller slaved to the vehicle light FSM.
// A debounced button press latches a request; the walk phase is granted only
// on the rising edge of vehicle red, followed by a flashing clearance. Loss of
// red or a multi-hot vehicle lamp aborts to steady DON'T-WALK; multi-hot also
// sets a sticky fault that blocks further grants until reset.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   red          in   vehicle red lamp (registered upstream)
//   yellow       in   vehicle yellow lamp
//   green        in   vehicle green lamp
//   ped_btn      in   raw pedestrian button, active high
//   walk         out  WALK lamp
//   dont_walk    out  DON'T-WALK lamp, flashes during clearance
//   req_pending  out  latched, not yet served request
//   countdown    out  remaining cycles of the current phase, 0 when idle
//   fault        out  sticky multi-hot lamp indication
// ----------------------------------------------------------------------------
module ped_signal_ctrl
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int WALK_CYCLES     = DEF_WALK_CYCLES,
    parameter int CLEAR_CYCLES    = DEF_CLEAR_CYCLES,
    parameter int FLASH_HALF      = DEF_FLASH_HALF,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic [CNT_W-1:0] countdown,
    output logic             fault
);

    localparam int FL_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    logic             w_press;
    logic             w_red_rise;
    logic             w_multi;

    logic             r_red_d;
    ped_state_e       r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_timer,     w_timer_nxt;
    logic [FL_W-1:0]  r_flash_cnt, w_flash_cnt_nxt;
    logic             r_flash_on,  w_flash_on_nxt;
    logic             r_req,       w_req_nxt;
    logic             r_fault,     w_fault_nxt;
    logic             r_walk,      w_walk_nxt;
    logic             r_dont_walk, w_dont_walk_nxt;

    ped_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (ped_btn),
        .o_press (w_press)
    );

    assign w_red_rise = red & ~r_red_d;
    assign w_multi    = (red & yellow) | (red & green) | (yellow & green);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red_d     <= 1'b0;
            r_state     <= DW_STEADY;
            r_timer     <= '0;
            r_flash_cnt <= '0;
            r_flash_on  <= 1'b0;
            r_req       <= 1'b0;
            r_fault     <= 1'b0;
            r_walk      <= 1'b0;
            r_dont_walk <= 1'b1;
        end else begin
            r_red_d     <= red;
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_flash_cnt <= w_flash_cnt_nxt;
            r_flash_on  <= w_flash_on_nxt;
            r_req       <= w_req_nxt;
            r_fault     <= w_fault_nxt;
            r_walk      <= w_walk_nxt;
            r_dont_walk <= w_dont_walk_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_flash_cnt_nxt = r_flash_cnt;
        w_flash_on_nxt  = r_flash_on;
        w_req_nxt       = r_req | w_press;
        w_fault_nxt     = r_fault | w_multi;

        unique case (r_state)
            DW_STEADY: begin
                w_timer_nxt = '0;
                if (w_red_rise && (r_req || w_press) && !r_fault && !w_multi) begin
                    w_state_nxt = WALK;
                    w_timer_nxt = CNT_W'(WALK_CYCLES - 1);
                    // Serving the request wins over a press landing on the same edge.
                    w_req_nxt   = 1'b0;
                end
            end
            WALK: begin
                if (w_multi || !red) begin
                    w_state_nxt = DW_STEADY;
                    w_timer_nxt = '0;
                end else if (r_timer == '0) begin
                    w_state_nxt     = CLEARANCE;
                    w_timer_nxt     = CNT_W'(CLEAR_CYCLES - 1);
                    w_flash_on_nxt  = 1'b1;
                    w_flash_cnt_nxt = FL_W'(FLASH_HALF - 1);
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            CLEARANCE: begin
                if (w_multi || !red || (r_timer == '0)) begin
                    w_state_nxt = DW_STEADY;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
                if (r_flash_cnt == '0) begin
                    w_flash_on_nxt  = ~r_flash_on;
                    w_flash_cnt_nxt = FL_W'(FLASH_HALF - 1);
                end else begin
                    w_flash_cnt_nxt = r_flash_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = DW_STEADY;
                w_timer_nxt = '0;
            end
        endcase

        // Lamps are computed from the next state so they leave the block registered.
        w_walk_nxt      = (w_state_nxt == WALK);
        w_dont_walk_nxt = (w_state_nxt == DW_STEADY) ||
                          ((w_state_nxt == CLEARANCE) && w_flash_on_nxt);
    end

    assign walk        = r_walk;
    assign dont_walk   = r_dont_walk;
    assign req_pending = r_req;
    assign fault       = r_fault;
    // The timer is forced to zero whenever DW_STEADY is entered or held.
    assign countdown   = r_timer;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ped_signal_ctrl
// Directed testbench for ped_signal_ctrl with default parameters
// (debounce 4, walk 30, clearance 15, flash half-period 2).
// ----------------------------------------------------------------------------
module tb_ped_signal_ctrl;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       red     = 1'b0;
    logic       yellow  = 1'b0;
    logic       green   = 1'b0;
    logic       ped_btn = 1'b0;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic [7:0] countdown;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;

    ped_signal_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .ped_btn     (ped_btn),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .req_pending (req_pending),
        .countdown   (countdown),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        green = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        chk("rst.walk",      walk,        0);
        chk("rst.dont_walk", dont_walk,   1);
        chk("rst.req",       req_pending, 0);
        chk("rst.countdown", countdown,   0);
        chk("rst.fault",     fault,       0);
        rst_n = 1'b1;
        step();

        // ---------------- press held 10 cycles during green ----------------
        ped_btn = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("press.req_early", req_pending, 0);
        step();
        chk("press.req_set", req_pending, 1);
        for (int i = 0; i < 4; i++) step();
        ped_btn = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("press.req_hold",  req_pending, 1);
        chk("press.walk_idle", walk,        0);
        chk("press.dw_idle",   dont_walk,   1);

        // ---------------- red rises: full walk + clearance ----------------
        green = 1'b0;
        red   = 1'b1;
        step();
        chk("walk.enter_walk", walk,        1);
        chk("walk.enter_dw",   dont_walk,   0);
        chk("walk.enter_cd",   countdown,   29);
        chk("walk.enter_req",  req_pending, 0);
        for (int i = 1; i < 30; i++) begin
            step();
            chk("walk.walk", walk,      1);
            chk("walk.dw",   dont_walk, 0);
            chk("walk.cd",   countdown, 29 - i);
        end
        for (int j = 0; j < 15; j++) begin
            step();
            chk("clr.walk", walk,      0);
            chk("clr.dw",   dont_walk, (((j / 2) % 2) == 0) ? 1 : 0);
            chk("clr.cd",   countdown, 14 - j);
        end
        step();
        chk("done.walk", walk,      0);
        chk("done.dw",   dont_walk, 1);
        chk("done.cd",   countdown, 0);
        step();
        step();
        chk("done.dw_steady", dont_walk, 1);

        // ---------------- 3-cycle glitch, then red with no request ----------------
        red   = 1'b0;
        green = 1'b1;
        step();
        step();
        ped_btn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        ped_btn = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("glitch.req", req_pending, 0);
        green = 1'b0;
        red   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("noreq.walk", walk,      0);
            chk("noreq.dw",   dont_walk, 1);
        end
        chk("noreq.cd", countdown, 0);

        // ---------------- abort at walk cycle 10, press during walk ----------------
        red   = 1'b0;
        green = 1'b1;
        step();
        ped_btn = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("abort.req_set", req_pending, 1);
        ped_btn = 1'b0;
        step();
        step();
        green = 1'b0;
        red   = 1'b1;
        step();
        chk("abort.enter_walk", walk,        1);
        chk("abort.enter_req",  req_pending, 0);
        ped_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 6) ped_btn = 1'b0;
        end
        chk("abort.mid_cd",   countdown,   19);
        chk("abort.mid_req",  req_pending, 1);
        red   = 1'b0;
        green = 1'b1;
        step();
        chk("abort.walk", walk,        0);
        chk("abort.dw",   dont_walk,   1);
        chk("abort.cd",   countdown,   0);
        chk("abort.req",  req_pending, 1);

        // ---------------- multi-hot lamps: sticky fault blocks grants ----------------
        red = 1'b1;
        step();
        chk("fault.set",  fault,     1);
        chk("fault.walk", walk,      0);
        chk("fault.dw",   dont_walk, 1);
        red = 1'b0;
        step();
        chk("fault.sticky", fault, 1);
        green = 1'b0;
        red   = 1'b1;
        step();
        chk("fault.nogrant_walk", walk,        0);
        chk("fault.nogrant_req",  req_pending, 1);
        for (int i = 0; i < 5; i++) step();
        chk("fault.still_walk",  walk,      0);
        chk("fault.still_dw",    dont_walk, 1);
        chk("fault.still_fault", fault,     1);

        // ---------------- asynchronous reset during clearance ----------------
        red   = 1'b0;
        green = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("rst2.fault", fault, 0);
        ped_btn = 1'b1;
        for (int i = 0; i < 6; i++) step();
        ped_btn = 1'b0;
        chk("rst2.req", req_pending, 1);
        green = 1'b0;
        red   = 1'b1;
        step();
        chk("rst2.walk", walk, 1);
        ped_btn = 1'b1;
        for (int i = 1; i < 30; i++) begin
            step();
            if (i == 6) ped_btn = 1'b0;
        end
        step();
        step();
        step();
        chk("rst2.clr_cd",   countdown,   12);
        chk("rst2.clr_req",  req_pending, 1);
        chk("rst2.clr_walk", walk,        0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2.async_walk",  walk,        0);
        chk("rst2.async_dw",    dont_walk,   1);
        chk("rst2.async_req",   req_pending, 0);
        chk("rst2.async_cd",    countdown,   0);
        chk("rst2.async_fault", fault,       0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rst2.after_walk", walk, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
